// File: rtl/reg_dump_reader.sv
// Walks register addresses FIRST_REG..LAST_REG through one register-file read
// port and streams each (address, data) pair out over a valid/ready handshake.
module reg_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | rd_addr presented, beat captured at the edge
    // SEND  | beat held on the output until accepted
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

    localparam logic [4:0] C_FIRST = 5'(FIRST_REG);
    localparam logic [4:0] C_LAST  = 5'(LAST_REG);

    state_t      r_state;
    logic [4:0]  r_addr;
    logic        r_valid;
    logic [4:0]  r_out_addr;
    logic [31:0] r_out_data;
    logic        r_last;
    logic        r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= C_FIRST;
            r_valid    <= 1'b0;
            r_out_addr <= 5'd0;
            r_out_data <= 32'd0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_addr  <= C_FIRST;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_addr  <= C_FIRST;
                        r_valid <= 1'b0;
                    end else begin
                        r_out_data <= rd_data;
                        r_out_addr <= r_addr;
                        r_last     <= (r_addr == C_LAST);
                        r_valid    <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    // abort wins over an accept landing in the same cycle
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_addr  <= C_FIRST;
                        r_valid <= 1'b0;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 5'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_addr  <= C_FIRST;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_addr  <= C_FIRST;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr   = r_addr;
    assign busy      = (r_state == S_READ) || (r_state == S_SEND);
    assign out_valid = r_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_last;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dump, backpressure, mid-dump writes,
// abort, asynchronous reset and a narrowed address range.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst, start, abort, ready;
    logic [4:0]  rd_addr, out_addr;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done;

    logic        start2, ready2;
    logic [4:0]  rd_addr2, out_addr2;
    logic [31:0] rd_data2, out_data2;
    logic        out_valid2, out_last2, busy2, done2;

    logic [31:0] regs  [32];
    logic [31:0] exp_v [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb rd_data  = (rd_addr  == 5'd0) ? 32'd0 : regs[rd_addr];
    always_comb rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : regs[rd_addr2];

    reg_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    reg_dump_reader #(.FIRST_REG(5), .LAST_REG(7)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .rd_addr(rd_addr2), .rd_data(rd_data2),
        .out_valid(out_valid2), .out_ready(ready2),
        .out_addr(out_addr2), .out_data(out_data2), .out_last(out_last2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issues one start and runs max_cyc cycles (cycle c = T_c after the start edge).
    task automatic scenario(input int stall_addr, input int stall_n, input int write_beat,
                            input int start_beat, input int abort_beat, input int rst_beat,
                            input int max_cyc, output int nbeats, output int done_cyc,
                            output int ndone);
        int   stall_cnt;
        logic after_abort;
        stall_cnt = 0; nbeats = 0; done_cyc = 0; ndone = 0; after_abort = 1'b0;
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= max_cyc; c++) begin
            start = 1'b0; abort = 1'b0; ready = 1'b1; rst = 1'b0;
            if (after_abort) begin
                chk("abort_idle", {30'd0, out_valid, busy}, 32'd0);
                after_abort = 1'b0;
            end
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (out_valid) begin
                if (int'(out_addr) == abort_beat) begin
                    abort = 1'b1;
                    after_abort = 1'b1;
                end else if (int'(out_addr) == rst_beat) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_async_ctl", {18'd0, out_valid, out_last, busy, done, out_addr, rd_addr}, 32'd0);
                    chk("rst_async_data", out_data, 32'd0);
                end else if (int'(out_addr) == stall_addr && stall_cnt < stall_n) begin
                    ready = 1'b0;
                    chk("stall_addr", {27'd0, out_addr}, 32'(stall_addr));
                    chk("stall_data", out_data, exp_v[stall_addr]);
                    chk("stall_rd_addr", {27'd0, rd_addr}, 32'(stall_addr));
                    stall_cnt++;
                end else begin
                    chk("beat_addr", {27'd0, out_addr}, 32'(nbeats));
                    chk("beat_data", out_data, exp_v[nbeats]);
                    chk("beat_last", {31'd0, out_last}, {31'd0, nbeats == 31});
                    if (nbeats == write_beat) begin
                        regs[20] = 32'hDEAD_BEEF;
                        regs[2]  = 32'h2222_2222;
                    end
                    if (nbeats == start_beat) start = 1'b1;
                    nbeats++;
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    int nb, dc, nd, n2;

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i]  = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
            exp_v[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        start2 = 1'b0; ready2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 10; i++) begin
            chk("idle_ctl", {18'd0, out_valid, out_last, busy, done, out_addr, rd_addr}, 32'd0);
            chk("idle_data", out_data, 32'd0);
            @(negedge clk);
        end

        // full dump
        scenario(-1, 0, -1, -1, -1, -1, 70, nb, dc, nd);
        chk("full_beats", 32'(nb), 32'd32);
        chk("full_done_cyc", 32'(dc), 32'd65);
        chk("full_done_cnt", 32'(nd), 32'd1);
        chk("full_busy_after", {31'd0, busy}, 32'd0);

        // backpressure on beat 3
        scenario(3, 5, -1, -1, -1, -1, 80, nb, dc, nd);
        chk("bp_beats", 32'(nb), 32'd32);
        chk("bp_done_cyc", 32'(dc), 32'd70);
        chk("bp_done_cnt", 32'(nd), 32'd1);

        // second start ignored, register writes during beat 5
        exp_v[20] = 32'hDEAD_BEEF;
        scenario(-1, 0, 5, 10, -1, -1, 75, nb, dc, nd);
        chk("wr_beats", 32'(nb), 32'd32);
        chk("wr_done_cyc", 32'(dc), 32'd65);
        chk("wr_done_cnt", 32'(nd), 32'd1);
        chk("wr_no_restart", {31'd0, busy}, 32'd0);
        regs[20] = 32'h1000_0014; regs[2] = 32'h1000_0002; exp_v[20] = 32'h1000_0014;

        // abort while beat 7 is offered and accepted in the same cycle
        scenario(-1, 0, -1, -1, 7, -1, 30, nb, dc, nd);
        chk("abort_beats", 32'(nb), 32'd7);
        chk("abort_done_cnt", 32'(nd), 32'd0);

        // restart after abort begins at address 0
        scenario(-1, 0, -1, -1, -1, -1, 70, nb, dc, nd);
        chk("restart_beats", 32'(nb), 32'd32);
        chk("restart_done_cyc", 32'(dc), 32'd65);

        // asynchronous reset at beat 12
        scenario(-1, 0, -1, -1, -1, 12, 40, nb, dc, nd);
        chk("rst_beats", 32'(nb), 32'd12);
        chk("rst_done_cnt", 32'(nd), 32'd0);

        // start and abort together in IDLE: start wins; then abort in READ
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_wins_busy", {31'd0, busy}, 32'd1);
        chk("start_wins_rd", {27'd0, rd_addr}, 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_read_idle", {30'd0, busy, out_valid}, 32'd0);
        @(negedge clk);
        chk("abort_read_nodone", {31'd0, done}, 32'd0);

        // narrowed range 5..7
        n2 = 0; dc = 0; nd = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (done2) begin
                nd++;
                if (dc == 0) dc = c;
            end
            if (out_valid2) begin
                chk("r2_addr", {27'd0, out_addr2}, 32'(5 + n2));
                chk("r2_data", out_data2, exp_v[5 + n2]);
                chk("r2_last", {31'd0, out_last2}, {31'd0, n2 == 2});
                n2++;
            end
            @(negedge clk);
        end
        chk("r2_beats", 32'(n2), 32'd3);
        chk("r2_done_cyc", 32'(dc), 32'd7);
        chk("r2_done_cnt", 32'(nd), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Sequential reader for the 32x32 register file: on request it walks a range of register addresses through one register-file read port and streams each (address, data) pair out over a valid/ready handshake. It sits between the datapath register file and the debug/display path (VGA/UART dump logic), which may backpressure. It is the read-side counterpart to the writeback path that fills the register file.

Parameters:
FIRST_REG, 0, first register address dumped (0..31)
LAST_REG, 31, last register address dumped (FIRST_REG..31)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request a dump; sampled only in IDLE
abort  input  1  synchronous cancel of a dump in progress
rd_addr  output  5  address to register-file read port
rd_data  input  32  combinational read data for rd_addr; x0 reads 0
out_valid  output  1  out_addr/out_data/out_last valid
out_ready  input  1  consumer accepts beat when out_valid && out_ready
out_addr  output  5  register address of current beat
out_data  output  32  register contents of current beat
out_last  output  1  current beat is LAST_REG
busy  output  1  high in READ or SEND
done  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async, any state): state=IDLE, addr counter=FIRST_REG, rd_addr=FIRST_REG, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0.
- Clock and reset are named clk and rst; one clock domain; reset is asynchronous and active-high.
- States: IDLE, READ, SEND, DONE. All outputs registered except rd_addr (= addr counter) and busy (decoded from state).
- IDLE: start=1 -> READ, counter=FIRST_REG. start=0 -> stay.
- READ (1 cycle): rd_addr=counter; at clock edge capture out_data<=rd_data, out_addr<=counter, out_last<=(counter==LAST_REG), out_valid<=1; -> SEND.
- SEND: out_valid=1; out_addr/out_data/out_last held stable until accepted. On accept: out_valid<=0; if out_last -> DONE, else counter<=counter+1 and -> READ. No accept -> stay.
- DONE: done=1 for exactly one cycle; -> IDLE; counter reset to FIRST_REG.
- Throughput: 2 cycles/beat with out_ready held high. Cycle of start edge = T0: READ in T1, first beat valid T2, next READ T3, ... Last beat accepted at end of T(2N); done=1 in T(2N+1), where N=LAST_REG-FIRST_REG+1.
- Data coherence: each register is sampled at its own READ cycle; a register write landing before that cycle is reflected, a later one is not. No whole-file snapshot.
- start while busy or in DONE: ignored, no restart, no queueing.
- abort in READ or SEND: -> IDLE next edge, out_valid<=0, no done pulse, counter<=FIRST_REG. abort takes priority over a simultaneous accept. abort in IDLE/DONE: no effect (DONE still pulses).
- start and abort together in IDLE: start wins (abort has nothing to cancel).
- Counter never wraps: LAST_REG terminates the walk; address 31 does not increment to 0.
- rst asserted mid-dump: immediate return to reset values; no done pulse; a subsequent start begins again at FIRST_REG.

Test Plan:
- Reset then idle: rst pulse, no start -> all outputs 0, rd_addr=0, busy=0 for 10 cycles.
- Full dump, out_ready=1, regfile preloaded xi=0x1000_0000+i (x0=0): start 1 cycle -> 32 beats, out_addr 0..31, out_data 0, 0x1000_0001..0x1000_001F, out_last only on addr 31, done high exactly at cycle 65 after start edge, busy low after.
- Backpressure: out_ready=0 for 5 cycles on beat addr 3 -> out_valid, out_addr=3, out_data stable all 5 cycles; no beat lost or duplicated; rd_addr stays 3.
- Start while busy plus register write mid-dump: second start at beat 10 ignored; write x20=0xDEADBEEF during beat 5 -> beat 20 carries 0xDEADBEEF; write x2 during beat 5 -> beat 2 keeps old value.
- Abort and reset mid-dump: abort during SEND of beat 7 with out_ready=1 -> beat not counted, IDLE next cycle, no done; then start -> restart at addr 0. rst at beat 12 -> outputs 0 immediately (asynchronous), no done.
- Parameter range FIRST_REG=5, LAST_REG=7: start -> exactly 3 beats addr 5,6,7, out_last on 7, done at cycle 7 after start edge.
